// File: rtl/d_mem_region_rsp_align.sv
// rtl/d_mem_region_rsp_align.sv - read-response / write-alignment unit for non-cache D-mem regions
// Lane-shifts stores and loads for byte-addressed regions and holds region read data across memory stalls.
module d_mem_region_rsp_align #(
  parameter int                     NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS-1:0] SHIFT_MASK  = 2'b10,
  parameter bit                     SIGN_EXT_EN = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_dmem_ready,
  input  logic                       i_req_valid_q103h,
  input  logic                       i_req_rd_q103h,
  input  logic                       i_req_sign_ext_q103h,
  input  logic [1:0]                 i_req_addr_q103h,
  input  logic [31:0]                i_req_wr_data_q103h,
  input  logic [3:0]                 i_req_byte_en_q103h,
  input  logic [NUM_REGIONS-1:0]     i_region_match_q103h,
  output logic [31:0]                o_shift_wr_data_q103h,
  output logic [3:0]                 o_shift_byte_en_q103h,
  input  logic [32*NUM_REGIONS-1:0]  i_region_rd_data_q104h,
  input  logic [31:0]                i_cache_rsp_data_q105h,
  output logic [31:0]                o_dmem_rd_rsp_q105h,
  output logic                       o_rsp_valid_q105h
);

  localparam int IDXW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int PW   = 9 + NUM_REGIONS;

  logic            w_hit_q103;
  logic [IDXW-1:0] w_idx_q103;
  logic            w_shift_q103;
  logic [PW-1:0]   w_req_q103;
  logic [PW-1:0]   r_req_q104;
  logic [PW-1:0]   r_req_q105;

  logic                   w_valid_q105;
  logic                   w_rd_q105;
  logic                   w_sext_q105;
  logic [1:0]             w_addr_q105;
  logic [3:0]             w_be_q105;
  logic [NUM_REGIONS-1:0] w_match_q105;

  logic            r_sample_rdy_q104;
  logic [31:0]     r_last_data [NUM_REGIONS];
  logic [31:0]     r_rd_data_q105 [NUM_REGIONS];
  logic [31:0]     w_held_q104 [NUM_REGIONS];

  logic            w_hit_q105;
  logic [IDXW-1:0] w_idx_q105;
  logic [31:0]     w_shifted_q105;
  logic            w_sign_q105;
  logic [31:0]     w_ext_q105;

  // Descending scan so the lowest set match bit is the last assignment and wins.
  always_comb begin
    w_hit_q103 = 1'b0;
    w_idx_q103 = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (i_region_match_q103h[i]) begin
        w_hit_q103 = 1'b1;
        w_idx_q103 = IDXW'(i);
      end
    end
  end

  assign w_shift_q103          = w_hit_q103 & SHIFT_MASK[w_idx_q103];
  assign o_shift_wr_data_q103h = w_shift_q103 ? (i_req_wr_data_q103h << {i_req_addr_q103h, 3'b000})
                                              : i_req_wr_data_q103h;
  assign o_shift_byte_en_q103h = w_shift_q103 ? (i_req_byte_en_q103h << i_req_addr_q103h)
                                              : i_req_byte_en_q103h;

  assign w_req_q103 = {i_req_valid_q103h, i_req_rd_q103h, i_req_sign_ext_q103h,
                       i_req_addr_q103h, i_req_byte_en_q103h, i_region_match_q103h};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_req_q104 <= '0;
      r_req_q105 <= '0;
    end else if (i_dmem_ready) begin
      r_req_q104 <= w_req_q103;
      r_req_q105 <= r_req_q104;
    end
  end

  assign {w_valid_q105, w_rd_q105, w_sext_q105, w_addr_q105, w_be_q105, w_match_q105} = r_req_q105;

  // Region data is only trusted on the cycle after a ready cycle; otherwise replay the last sample.
  always_comb begin
    for (int i = 0; i < NUM_REGIONS; i++) begin
      w_held_q104[i] = r_sample_rdy_q104 ? i_region_rd_data_q104h[32*i +: 32] : r_last_data[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sample_rdy_q104 <= 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_last_data[i]    <= '0;
        r_rd_data_q105[i] <= '0;
      end
    end else begin
      r_sample_rdy_q104 <= i_dmem_ready;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (r_sample_rdy_q104) r_last_data[i] <= i_region_rd_data_q104h[32*i +: 32];
        r_rd_data_q105[i] <= w_held_q104[i];
      end
    end
  end

  always_comb begin
    w_hit_q105 = 1'b0;
    w_idx_q105 = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (w_match_q105[i]) begin
        w_hit_q105 = 1'b1;
        w_idx_q105 = IDXW'(i);
      end
    end
  end

  assign w_shifted_q105 = SHIFT_MASK[w_idx_q105] ? (r_rd_data_q105[w_idx_q105] >> {w_addr_q105, 3'b000})
                                                 : r_rd_data_q105[w_idx_q105];
  assign w_sign_q105    = w_sext_q105 & SIGN_EXT_EN;

  always_comb begin
    case (w_be_q105)
      4'b0001: w_ext_q105 = {{24{w_sign_q105 & w_shifted_q105[7]}},  w_shifted_q105[7:0]};
      4'b0011: w_ext_q105 = {{16{w_sign_q105 & w_shifted_q105[15]}}, w_shifted_q105[15:0]};
      default: w_ext_q105 = w_shifted_q105;
    endcase
  end

  assign o_dmem_rd_rsp_q105h = w_hit_q105 ? w_ext_q105 : i_cache_rsp_data_q105h;
  assign o_rsp_valid_q105h   = w_valid_q105 & w_rd_q105 & i_dmem_ready;

endmodule

// File: tb/tb_d_mem_region_rsp_align.sv
// tb/tb_d_mem_region_rsp_align.sv - directed vector bench for d_mem_region_rsp_align
// Table vectors for write shift and unstalled loads, hand sequences for stall hold and reset.
module tb_d_mem_region_rsp_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_ready;
  logic        req_valid;
  logic        req_rd;
  logic        req_sext;
  logic [1:0]  req_addr;
  logic [31:0] req_wr_data;
  logic [3:0]  req_be;
  logic [1:0]  req_match;
  logic [31:0] shift_wr_data;
  logic [3:0]  shift_be;
  logic [63:0] region_rd_data;
  logic [31:0] cache_rsp;
  logic [31:0] rd_rsp;
  logic        rsp_valid;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  d_mem_region_rsp_align #(
    .NUM_REGIONS (2),
    .SHIFT_MASK  (2'b10),
    .SIGN_EXT_EN (1'b1)
  ) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_dmem_ready           (dmem_ready),
    .i_req_valid_q103h      (req_valid),
    .i_req_rd_q103h         (req_rd),
    .i_req_sign_ext_q103h   (req_sext),
    .i_req_addr_q103h       (req_addr),
    .i_req_wr_data_q103h    (req_wr_data),
    .i_req_byte_en_q103h    (req_be),
    .i_region_match_q103h   (req_match),
    .o_shift_wr_data_q103h  (shift_wr_data),
    .o_shift_byte_en_q103h  (shift_be),
    .i_region_rd_data_q104h (region_rd_data),
    .i_cache_rsp_data_q105h (cache_rsp),
    .o_dmem_rd_rsp_q105h    (rd_rsp),
    .o_rsp_valid_q105h      (rsp_valid)
  );

  typedef struct {
    logic [1:0]  match;
    logic [1:0]  addr;
    logic [31:0] wr;
    logic [3:0]  be;
    logic [31:0] exp_wr;
    logic [3:0]  exp_be;
  } wr_vec_t;

  typedef struct {
    logic [1:0]  match;
    logic        sext;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] cache;
    logic [31:0] exp;
  } rd_vec_t;

  wr_vec_t wv [6];
  rd_vec_t rv [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_load(input logic [1:0] match, input logic sext, input logic [1:0] addr,
                            input logic [3:0] be);
    req_valid = 1'b1;
    req_rd    = 1'b1;
    req_sext  = sext;
    req_addr  = addr;
    req_be    = be;
    req_match = match;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_rd    = 1'b0;
    req_match = 2'b00;
  endtask

  initial begin
    wv[0] = '{2'b10, 2'd2, 32'h0000ABCD, 4'b0011, 32'hABCD0000, 4'b1100};
    wv[1] = '{2'b01, 2'd2, 32'h0000ABCD, 4'b0011, 32'h0000ABCD, 4'b0011};
    wv[2] = '{2'b10, 2'd3, 32'h000000EF, 4'b0001, 32'hEF000000, 4'b1000};
    wv[3] = '{2'b00, 2'd1, 32'h12345678, 4'b1111, 32'h12345678, 4'b1111};
    wv[4] = '{2'b11, 2'd1, 32'h000000AA, 4'b0001, 32'h000000AA, 4'b0001};
    wv[5] = '{2'b10, 2'd1, 32'h11223344, 4'b1111, 32'h22334400, 4'b1110};

    rv[0] = '{2'b10, 1'b1, 2'd3, 4'b0001, 32'h0, 32'h80123456, 32'h0, 32'hFFFFFF80};
    rv[1] = '{2'b10, 1'b0, 2'd3, 4'b0001, 32'h0, 32'h80123456, 32'h0, 32'h00000080};
    rv[2] = '{2'b00, 1'b0, 2'd1, 4'b1111, 32'h0, 32'h0, 32'h12345678, 32'h12345678};
    rv[3] = '{2'b11, 1'b1, 2'd2, 4'b0011, 32'h00007FFF, 32'h80010000, 32'h0, 32'h00007FFF};
    rv[4] = '{2'b10, 1'b1, 2'd2, 4'b0011, 32'h0, 32'h80010000, 32'h0, 32'hFFFF8001};
    rv[5] = '{2'b01, 1'b1, 2'd2, 4'b0001, 32'h000000F0, 32'h0, 32'h0, 32'hFFFFFFF0};
    rv[6] = '{2'b01, 1'b0, 2'd0, 4'b1111, 32'hCAFEF00D, 32'h0, 32'h0, 32'hCAFEF00D};

    rst = 1'b1;
    dmem_ready = 1'b1;
    idle_req();
    req_sext = 1'b0;
    req_addr = 2'd0;
    req_be = 4'b0000;
    req_wr_data = 32'h0;
    region_rd_data = 64'h0;
    cache_rsp = 32'h5A5A5A5A;
    cyc();
    cyc();
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_data", rd_rsp, 32'h5A5A5A5A);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_rd = 1'b0;
      req_match = wv[i].match;
      req_addr = wv[i].addr;
      req_wr_data = wv[i].wr;
      req_be = wv[i].be;
      #1;
      check($sformatf("wr_data[%0d]", i), shift_wr_data, wv[i].exp_wr);
      check($sformatf("wr_be[%0d]", i), {28'd0, shift_be}, {28'd0, wv[i].exp_be});
      cyc();
    end
    idle_req();
    cyc();
    check("store_q105_no_rsp", {31'd0, rsp_valid}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      issue_load(rv[i].match, rv[i].sext, rv[i].addr, rv[i].be);
      cyc();
      idle_req();
      region_rd_data = {rv[i].r1, rv[i].r0};
      cyc();
      cache_rsp = rv[i].cache;
      #1;
      check($sformatf("ld_valid[%0d]", i), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("ld_data[%0d]", i), rd_rsp, rv[i].exp);
    end
    cyc();
    check("ld_valid_single_pulse", {31'd0, rsp_valid}, 32'd0);

    // Load held over a 3-cycle stall; garbage driven while stalled must be ignored.
    issue_load(2'b01, 1'b0, 2'd0, 4'b1111);
    cyc();
    idle_req();
    dmem_ready = 1'b0;
    region_rd_data = {32'h0, 32'hCAFEF00D};
    #1;
    check("stall_c1_valid", {31'd0, rsp_valid}, 32'd0);
    cyc();
    region_rd_data = {32'h0, 32'hDEADBEEF};
    #1;
    check("stall_c2_valid", {31'd0, rsp_valid}, 32'd0);
    cyc();
    #1;
    check("stall_c3_valid", {31'd0, rsp_valid}, 32'd0);
    cyc();
    dmem_ready = 1'b1;
    #1;
    check("stall_release_wait", {31'd0, rsp_valid}, 32'd0);
    cyc();
    #1;
    check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("stall_rsp_data", rd_rsp, 32'hCAFEF00D);
    cyc();
    check("stall_pulse_end", {31'd0, rsp_valid}, 32'd0);

    // Reset mid-stall, then a fresh CR load must not see the pre-reset data.
    issue_load(2'b01, 1'b0, 2'd0, 4'b1111);
    cyc();
    idle_req();
    dmem_ready = 1'b0;
    region_rd_data = {32'h0, 32'hCAFEF00D};
    cyc();
    region_rd_data = {32'h0, 32'hDEADBEEF};
    cache_rsp = 32'h0BADF00D;
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_data", rd_rsp, 32'h0BADF00D);
    cyc();
    rst = 1'b0;
    dmem_ready = 1'b1;
    cyc();
    check("post_rst_idle", {31'd0, rsp_valid}, 32'd0);
    issue_load(2'b01, 1'b0, 2'd0, 4'b1111);
    cyc();
    idle_req();
    region_rd_data = {32'h0, 32'h13572468};
    cyc();
    #1;
    check("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
    check("post_rst_data", rd_rsp, 32'h13572468);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
